cok_dongulu_aritmetik_birim: RTL and testbench

//  XLEN-parametrised execute-stage arithmetic unit for the RISC-V core; next generation of the single-cycle ALU.

---
 rtl/cok_dongulu_aritmetik_birim.sv | 144 ++++++++++++++
 tb/tb_cok_dongulu_aritmetik_birim.sv | 132 +++++++++++++
 2 files changed

// File: rtl/cok_dongulu_aritmetik_birim.sv
// cok_dongulu_aritmetik_birim: registered execute-stage ALU with handshake, abort and optional iterative RV32M (CARPMA_BOLME_EN)
module cok_dongulu_aritmetik_birim #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [4:0]      kontrol_i,
  input  logic [XLEN-1:0] deger1_i,
  input  logic [XLEN-1:0] deger2_i,
  input  logic            iptal_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] sonuc_o,
  output logic            sifir_o,
  output logic            hata_o
);
`ifdef CARPMA_BOLME_EN
  typedef enum logic [1:0] {BOS, HESAPLA, SONUC} durum_t;
`else
  typedef enum logic {BOS, SONUC} durum_t;
`endif
  durum_t durum_q, durum_d;
  logic [XLEN-1:0] sonuc_q, tek_sonuc;
  logic hata_q, tek_hata, kabul;
  logic [SHAMT_W-1:0] shamt;
  assign shamt   = deger2_i[SHAMT_W-1:0];
  assign kabul   = durum_q == BOS && valid_i && !iptal_i;
  assign ready_o = durum_q == BOS;
  assign valid_o = durum_q == SONUC;
  assign sonuc_o = sonuc_q;
  assign sifir_o = sonuc_q == '0;
  assign hata_o  = hata_q;
`ifdef CARPMA_BOLME_EN
  logic m_islem, bolme, s1, s2, n1, n2, neg, neg_q, sifir_bol, tasma, ozel;
  logic [XLEN-1:0] mag1, mag2, a_q, bolum_deger, m_sonuc;
  logic [2*XLEN-1:0] p_q, p_ilk, p_sonraki, carpim;
  logic [XLEN:0] toplam, kayma, fark;
  logic [2:0] op_q;
  logic [SHAMT_W:0] sayac_q;
  assign m_islem   = kontrol_i[4:3] == 2'b10;
  assign bolme     = kontrol_i[2];
  assign s1        = bolme ? !kontrol_i[0] : kontrol_i[1] ^ kontrol_i[0];
  assign s2        = bolme ? !kontrol_i[0] : kontrol_i[1:0] == 2'b01;
  assign n1        = s1 & deger1_i[XLEN-1];
  assign n2        = s2 & deger2_i[XLEN-1];
  assign mag1      = n1 ? -deger1_i : deger1_i;
  assign mag2      = n2 ? -deger2_i : deger2_i;
  assign neg       = (bolme & kontrol_i[1]) ? n1 : n1 ^ n2;
  assign sifir_bol = m_islem & bolme & deger2_i == '0;
  assign tasma     = m_islem & bolme & !kontrol_i[0] & deger1_i == {1'b1, {(XLEN-1){1'b0}}} & deger2_i == '1;
  assign ozel      = sifir_bol | tasma;
  // multiplier sits in the low half for shift-add; dividend sits there for restoring divide
  assign p_ilk     = {{XLEN{1'b0}}, bolme ? mag1 : mag2};
  assign toplam    = {1'b0, p_q[2*XLEN-1:XLEN]} + {1'b0, p_q[0] ? a_q : {XLEN{1'b0}}};
  assign kayma     = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
  assign fark      = kayma - {1'b0, a_q};
  assign p_sonraki = op_q[2] ? (fark[XLEN] ? {kayma[XLEN-1:0], p_q[XLEN-2:0], 1'b0}
                                           : {fark[XLEN-1:0], p_q[XLEN-2:0], 1'b1})
                             : {toplam, p_q[XLEN-1:1]};
  assign carpim      = neg_q ? -p_q : p_q;
  assign bolum_deger = op_q[1] ? p_q[2*XLEN-1:XLEN] : p_q[XLEN-1:0];
  assign m_sonuc     = op_q[2] ? (neg_q ? -bolum_deger : bolum_deger)
                     : op_q[1:0] == 2'b00 ? carpim[XLEN-1:0] : carpim[2*XLEN-1:XLEN];
`endif
  // single-cycle result, illegal-code detection and early-resolved divide corner cases
  always_comb begin
    tek_sonuc = '0;
    tek_hata  = 1'b0;
    case (kontrol_i)
      5'd0:    tek_sonuc = deger1_i + deger2_i;
      5'd1:    tek_sonuc = deger1_i - deger2_i;
      5'd2:    tek_sonuc = deger1_i ^ deger2_i;
      5'd3:    tek_sonuc = deger1_i | deger2_i;
      5'd4:    tek_sonuc = deger1_i & deger2_i;
      5'd5:    tek_sonuc = deger1_i << shamt;
      5'd6:    tek_sonuc = deger1_i >> shamt;
      5'd7:    tek_sonuc = $signed(deger1_i) >>> shamt;
      5'd8:    tek_sonuc = {{(XLEN-1){1'b0}}, $signed(deger1_i) < $signed(deger2_i)};
      5'd9:    tek_sonuc = {{(XLEN-1){1'b0}}, deger1_i < deger2_i};
      5'd10:   tek_sonuc = deger2_i;
      default: tek_hata  = 1'b1;
    endcase
`ifdef CARPMA_BOLME_EN
    if (m_islem) begin
      tek_hata  = 1'b0;
      tek_sonuc = sifir_bol ? (kontrol_i[1] ? deger1_i : '1) : tasma ? (kontrol_i[1] ? '0 : deger1_i) : '0;
    end
`endif
  end
  // state register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) durum_q <= BOS;
    else durum_q <= durum_d;
  // next state: abort wins over everything, result holds until consumed
  always_comb begin
    durum_d = durum_q;
    if (iptal_i) durum_d = BOS;
    else
      case (durum_q)
`ifdef CARPMA_BOLME_EN
        BOS:     if (valid_i) durum_d = (m_islem && !ozel) ? HESAPLA : SONUC;
        HESAPLA: if (sayac_q == '0) durum_d = SONUC;
`else
        BOS:     if (valid_i) durum_d = SONUC;
`endif
        SONUC:   if (ready_i) durum_d = BOS;
        default: durum_d = BOS;
      endcase
  end
  // result capture at accept; iterative datapath steps then applies the sign fix-up on the final cycle
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sonuc_q <= '0;
      hata_q  <= 1'b0;
`ifdef CARPMA_BOLME_EN
      p_q     <= '0;
      a_q     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      sayac_q <= '0;
`endif
    end else if (kabul) begin
      sonuc_q <= tek_sonuc;
      hata_q  <= tek_hata;
`ifdef CARPMA_BOLME_EN
      p_q     <= p_ilk;
      a_q     <= bolme ? mag2 : mag1;
      op_q    <= kontrol_i[2:0];
      neg_q   <= neg;
      sayac_q <= (m_islem && !ozel) ? (SHAMT_W+1)'(XLEN) : '0;
    end else if (iptal_i) begin
      sayac_q <= '0;
    end else if (durum_q == HESAPLA) begin
      if (sayac_q == '0) sonuc_q <= m_sonuc;
      else begin
        p_q     <= p_sonraki;
        sayac_q <= sayac_q - 1'b1;
      end
`endif
    end
endmodule

// File: tb/tb_cok_dongulu_aritmetik_birim.sv
// tb_cok_dongulu_aritmetik_birim: directed self-checking bench for the multi-cycle arithmetic unit
module tb_cok_dongulu_aritmetik_birim;
  logic clk_i = 1'b0, rst_ni = 1'b0, valid_i = 1'b0, iptal_i = 1'b0, ready_i = 1'b1;
  logic ready_o, valid_o, sifir_o, hata_o;
  logic [4:0] kontrol_i = '0;
  logic [31:0] deger1_i = '0, deger2_i = '0, sonuc_o;
  int kontrol_sayisi = 0, hata_sayisi = 0;
  cok_dongulu_aritmetik_birim #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o), .kontrol_i(kontrol_i),
    .deger1_i(deger1_i), .deger2_i(deger2_i), .iptal_i(iptal_i), .valid_o(valid_o), .ready_i(ready_i),
    .sonuc_o(sonuc_o), .sifir_o(sifir_o), .hata_o(hata_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic kontrol(input string tag, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    kontrol_sayisi++;
    assert (gozlenen === beklenen) else begin
      hata_sayisi++;
      $error("FAIL %s observed=%h expected=%h", tag, gozlenen, beklenen);
    end
  endtask
  task automatic calistir(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int gecikme, input logic [31:0] beklenen, input logic hata_bek, input int tut);
    int n;
    @(negedge clk_i);
    kontrol_i = op; deger1_i = a; deger2_i = b; valid_i = 1'b1; ready_i = (tut == 0);
    @(posedge clk_i); #1;
    valid_i = 1'b0; kontrol_i = 5'd10; deger1_i = $urandom; deger2_i = $urandom;
    n = 1;
    while (!valid_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    kontrol({tag, " gecikme"}, n, gecikme);
    kontrol({tag, " sonuc"}, sonuc_o, beklenen);
    kontrol({tag, " sifir"}, sifir_o, beklenen == 32'h0);
    kontrol({tag, " hata"}, hata_o, hata_bek);
    kontrol({tag, " ready_o"}, ready_o, 1'b0);
    if (tut > 0) begin
      repeat (tut) begin
        @(posedge clk_i); #1;
      end
      kontrol({tag, " tutulan sonuc"}, sonuc_o, beklenen);
      kontrol({tag, " tutulan valid"}, valid_o, 1'b1);
      @(negedge clk_i);
      ready_i = 1'b1;
    end
    @(posedge clk_i); #1;
    kontrol({tag, " donus valid"}, valid_o, 1'b0);
    kontrol({tag, " donus ready"}, ready_o, 1'b1);
  endtask
  initial begin
    int goruldu;
    #3;
    kontrol("reset valid", valid_o, 1'b0);
    kontrol("reset sonuc", sonuc_o, 32'h0);
    kontrol("reset sifir", sifir_o, 1'b1);
    kontrol("reset hata", hata_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    kontrol("reset sonrasi ready", ready_o, 1'b1);
    calistir("ADD", 5'd0, 32'hFFFFFFFF, 32'h1, 1, 32'h0, 1'b0, 0);
    calistir("SUB", 5'd1, 32'd5, 32'd7, 1, 32'hFFFFFFFE, 1'b0, 0);
    calistir("SRA", 5'd7, 32'h80000000, 32'h24, 1, 32'hF8000000, 1'b0, 0);
    calistir("SLL", 5'd5, 32'h1, 32'h3F, 1, 32'h80000000, 1'b0, 0);
    calistir("SRL", 5'd6, 32'h80000000, 32'h21, 1, 32'h40000000, 1'b0, 0);
    calistir("XOR", 5'd2, 32'hA5A5A5A5, 32'hFFFF0000, 1, 32'h5A5AA5A5, 1'b0, 0);
    calistir("OR", 5'd3, 32'h0F0F0000, 32'h000000F0, 1, 32'h0F0F00F0, 1'b0, 0);
    calistir("AND", 5'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 1, 32'h00F000F0, 1'b0, 0);
    calistir("SLT", 5'd8, 32'hFFFFFFFF, 32'h1, 1, 32'h1, 1'b0, 0);
    calistir("SLTU", 5'd9, 32'hFFFFFFFF, 32'h1, 1, 32'h0, 1'b0, 0);
    calistir("GECIR", 5'd10, 32'hDEADBEEF, 32'h12345678, 1, 32'h12345678, 1'b0, 0);
    calistir("yasadisi 11", 5'd11, 32'h5, 32'h6, 1, 32'h0, 1'b1, 0);
    calistir("yasadisi 31", 5'd31, 32'h5, 32'h6, 1, 32'h0, 1'b1, 0);
`ifdef CARPMA_BOLME_EN
    calistir("MULHU", 5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 1'b0, 0);
    calistir("MULH", 5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h0, 1'b0, 0);
    calistir("MUL", 5'd16, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFEB, 1'b0, 0);
    calistir("MULHSU", 5'd18, 32'hFFFFFFFF, 32'h2, 33, 32'hFFFFFFFF, 1'b0, 0);
    calistir("DIV tasma", 5'd20, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 1'b0, 0);
    calistir("REM tasma", 5'd22, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 1'b0, 0);
    calistir("DIVU sifir", 5'd21, 32'h1234, 32'h0, 1, 32'hFFFFFFFF, 1'b0, 0);
    calistir("REMU sifir", 5'd23, 32'h1234, 32'h0, 1, 32'h1234, 1'b0, 0);
    calistir("DIV -7/2", 5'd20, 32'hFFFFFFF9, 32'h2, 33, 32'hFFFFFFFD, 1'b0, 3);
    calistir("REM -7/2", 5'd22, 32'hFFFFFFF9, 32'h2, 33, 32'hFFFFFFFF, 1'b0, 0);
    calistir("REM 7/-2", 5'd22, 32'd7, 32'hFFFFFFFE, 33, 32'h1, 1'b0, 0);
    calistir("DIVU 100/7", 5'd21, 32'd100, 32'd7, 33, 32'hE, 1'b0, 0);
    calistir("REMU 100/7", 5'd23, 32'd100, 32'd7, 33, 32'h2, 1'b0, 0);
    @(negedge clk_i);
    kontrol_i = 5'd21; deger1_i = 32'd100; deger2_i = 32'd7; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    kontrol("iptal oncesi ready", ready_o, 1'b0);
    repeat (8) @(posedge clk_i);
    @(negedge clk_i);
    iptal_i = 1'b1;
    @(posedge clk_i); #1;
    iptal_i = 1'b0;
    kontrol("iptal valid", valid_o, 1'b0);
    kontrol("iptal ready", ready_o, 1'b1);
    goruldu = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (valid_o) goruldu = 1;
    end
    kontrol("iptal sonrasi sonuc yok", goruldu, 0);
`else
    calistir("MUL kapali", 5'd16, 32'd7, 32'd3, 1, 32'h0, 1'b1, 0);
    calistir("REMU kapali", 5'd23, 32'd7, 32'd3, 1, 32'h0, 1'b1, 0);
`endif
    @(negedge clk_i);
    kontrol_i = 5'd0; deger1_i = 32'd1; deger2_i = 32'd2; valid_i = 1'b1; iptal_i = 1'b1;
    @(posedge clk_i); #1;
    kontrol("iptal oncelik valid", valid_o, 1'b0);
    kontrol("iptal oncelik ready", ready_o, 1'b1);
    valid_i = 1'b0; iptal_i = 1'b0;
    @(posedge clk_i); #1;
    kontrol("iptal oncelik sonra", valid_o, 1'b0);
    @(negedge clk_i);
    kontrol_i = 5'd12; valid_i = 1'b1; ready_i = 1'b0;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    kontrol("bekleyen hata", hata_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    kontrol("async reset valid", valid_o, 1'b0);
    kontrol("async reset hata", hata_o, 1'b0);
    kontrol("async reset ready", ready_o, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", kontrol_sayisi, hata_sayisi);
    $finish;
  end
endmodule
